rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, ROM depth in 32-bit words = 2^ADDR_W.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000, idle cycles tolerated between bytes.
REQ-003 SHALL use one clock; reset asynchronous, active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse, begins a load.
REQ-007 rx_data  input  8  received byte from UART receiver.
REQ-008 rx_valid  input  1  rx_data valid this cycle, one byte per pulse.
REQ-009 rom_we  output  1  ROM write strobe, one cycle per word.
REQ-010 rom_waddr  output  32  ROM byte address of write.
REQ-011 rom_wdata  output  32  ROM write word.
REQ-012 cpu_hold  output  1  high holds CPU core in reset.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  last load completed successfully.
REQ-015 err  output  1  last load aborted.

Function
REQ-016 SHALL implement states IDLE, LEN, DATA, CHK, DONE, ERR.
REQ-017 IDLE/DONE/ERR: start -> LEN; clear word count, byte count, address, checksum; busy=1 from next cycle.
REQ-018 start while busy SHALL be ignored; rx_valid outside LEN/DATA/CHK SHALL be ignored.
REQ-019 LEN: first 4 bytes SHALL form word count N, little-endian (first byte = bits 7:0).
REQ-020 N=0 SHALL go directly to DONE (or CHK if enabled); N>2^ADDR_W SHALL go to ERR.
REQ-021 DATA: bytes assembled little-endian; on 4th byte accepted, rom_we=1 the next cycle with rom_wdata = word, rom_waddr = 4*index, index from 0.
REQ-022 rom_we SHALL be high exactly one cycle per word, never otherwise; rom_waddr/rom_wdata stable while rom_we high.
REQ-023 After the N-th write strobe, SHALL go to DONE (or CHK) the following cycle.
REQ-024 Timeout counter SHALL reset on every accepted byte and on entry to LEN; reaching TIMEOUT_CYC in LEN/DATA/CHK -> ERR.
REQ-025 cpu_hold SHALL be 1 in LEN, DATA, CHK, ERR; 0 in IDLE and DONE.
REQ-026 done=1 only in DONE; err=1 only in ERR; both held until next accepted start.
REQ-027 Byte count and address SHALL not wrap; index max 2^ADDR_W-1 guaranteed by REQ-020.

Reset
REQ-028 Reset SHALL force IDLE; rom_we=0, rom_waddr=0, rom_wdata=0, busy=0, done=0, err=0, cpu_hold=0.
REQ-029 Reset mid-load SHALL abandon the load immediately with no further rom_we; partial ROM contents left as written.

Configuration
REQ-030 Macro ROM_LOADER_CHECKSUM_EN: defined -> after data, one extra byte SHALL be compared with 8-bit sum (mod 256) of all data bytes; match -> DONE, mismatch -> ERR.
REQ-031 Without ROM_LOADER_CHECKSUM_EN, state CHK and checksum logic SHALL be absent; DATA -> DONE directly.

Structure
REQ-032 State encodings, LEN_BYTES=4 and default TIMEOUT_CYC SHALL live in shared package/defines file loader_defs.
REQ-033 Timeout counter SHALL be sub-module loader_timeout_cnt (inputs clk, rst, clr, en; output expired).

Verification
REQ-034 start, bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> rom_we twice: addr 0 data 12345678, addr 4 data DEADBEEF; done=1, cpu_hold=0.
REQ-035 start, count bytes 00 00 00 00 -> no rom_we; done=1 (checksum build: after extra byte 00).
REQ-036 ADDR_W=4, count 17 -> err=1, cpu_hold=1, no rom_we.
REQ-037 TIMEOUT_CYC=100, count 1, two data bytes then silence -> err=1 at 100 idle cycles, no rom_we.
REQ-038 rst asserted after 1st of 2 words written -> all outputs at reset values next edge, no second rom_we; second start pulse during load ignored.
REQ-039 ROM_LOADER_CHECKSUM_EN, count 1, data 01 02 03 04, checksum 0A -> done=1; checksum 0B -> err=1.

Source files
------------

// File: rtl/loader_defs.sv
// loader_defs: definitions shared by the ROM loader block.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - LEN_BYTES: number of bytes in the little-endian word-count header
//   - DEFAULT_TIMEOUT_CYC: default idle-cycle limit between received bytes
//   - is_active(): true for states in which a load is in progress
// Optional feature macro: ROM_LOADER_CHECKSUM_EN adds the CHK state.
package loader_defs;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam int LEN_BYTES           = 4;
  localparam int DEFAULT_TIMEOUT_CYC = 1000000;

  // A load is in progress while the loader is consuming header, data or
  // checksum bytes; these are the states where rx bytes and timeouts matter.
  function automatic logic is_active(input logic [2:0] s);
`ifdef ROM_LOADER_CHECKSUM_EN
    return (s == S_LEN) || (s == S_DATA) || (s == S_CHK);
`else
    return (s == S_LEN) || (s == S_DATA);
`endif
  endfunction

endpackage

// File: rtl/loader_timeout_cnt.sv
// loader_timeout_cnt: idle-cycle counter for the ROM loader.
// Counts enabled cycles since the last clear and raises 'expired' once the
// count reaches TIMEOUT_CYC. The count saturates there until cleared.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   clr     - restart counting from zero (has priority over en)
//   en      - count this cycle
//   expired - count has reached TIMEOUT_CYC
module loader_timeout_cnt
  import loader_defs::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: loads a program image received byte-by-byte (e.g. from a UART)
// into a 32-bit-wide ROM while holding the CPU core in reset.
// Stream format: 4-byte little-endian word count N, then N little-endian
// 32-bit words, then (only with ROM_LOADER_CHECKSUM_EN defined) one byte that
// must equal the mod-256 sum of all data bytes.
// Ports:
//   clk, rst              - clock and asynchronous active-high reset
//   start                 - one-cycle pulse, begins a load (ignored while busy)
//   rx_data, rx_valid     - received byte and its qualifier
//   rom_we                - one-cycle write strobe per word
//   rom_waddr, rom_wdata  - byte address (4*index) and data of the write
//   cpu_hold              - holds the CPU in reset during/after a bad load
//   busy, done, err       - load in progress / last load ok / last load aborted
// Configuration macro: ROM_LOADER_CHECKSUM_EN (adds trailing checksum byte).
module rom_loader
  import loader_defs::*;
#(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rom_we,
  output logic [31:0] rom_waddr,
  output logic [31:0] rom_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_AFTER_DATA = S_CHK;
`else
  localparam logic [2:0] S_AFTER_DATA = S_DONE;
`endif

  logic [2:0]      state;
  logic [1:0]      byte_cnt;
  logic [31:0]     shift_buf;
  logic [31:0]     word_len;
  logic [ADDR_W:0] word_idx;
  logic [31:0]     full_word;
  logic            active;
  logic            start_acc;
  logic            byte_acc;
  logic            expired;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]      checksum;
`endif

  assign active    = is_active(state);
  assign start_acc = start && !active;
  assign byte_acc  = rx_valid && active;
  // The byte arriving now completes the word together with the 3 buffered ones.
  assign full_word = {rx_data, shift_buf[23:0]};

  assign busy     = active;
  assign cpu_hold = active || (state == S_ERR);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);

  loader_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_acc || byte_acc),
    .en     (active),
    .expired(expired)
  );

  // Main load sequencer. shift_buf first collects the word count, then is
  // reused to assemble each data word. word_idx counts words already written,
  // so once the last strobe is out it equals word_len and we leave DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      shift_buf <= '0;
      word_len  <= '0;
      word_idx  <= '0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      if (start_acc) begin
        state     <= S_LEN;
        byte_cnt  <= '0;
        shift_buf <= '0;
        word_len  <= '0;
        word_idx  <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
        checksum  <= '0;
`endif
      end else begin
        case (state)
          S_LEN: begin
            if (expired) begin
              state <= S_ERR;
            end else if (rx_valid) begin
              shift_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'(LEN_BYTES - 1)) begin
                word_len <= full_word;
                if (full_word == '0) begin
                  state <= S_AFTER_DATA;
                end else if ({1'b0, full_word} > MAX_WORDS) begin
                  state <= S_ERR;
                end else begin
                  state <= S_DATA;
                end
              end
            end
          end
          S_DATA: begin
            if (rom_we && (32'(word_idx) == word_len)) begin
              state <= S_AFTER_DATA;
            end else if (expired) begin
              state <= S_ERR;
            end else if (rx_valid) begin
              shift_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
              byte_cnt <= byte_cnt + 2'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
              checksum <= checksum + rx_data;
`endif
              if (byte_cnt == 2'd3) begin
                rom_we    <= 1'b1;
                rom_waddr <= 32'({word_idx, 2'b00});
                rom_wdata <= full_word;
                word_idx  <= word_idx + 1'b1;
              end
            end
          end
`ifdef ROM_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (expired) begin
              state <= S_ERR;
            end else if (rx_valid) begin
              state <= (rx_data == checksum) ? S_DONE : S_ERR;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader (ADDR_W=4, TIMEOUT_CYC=100).
// Stimulus pushes expected ROM writes into a queue; a monitor pops and
// compares on every rom_we. Also honours ROM_LOADER_CHECKSUM_EN.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rom_we;
  logic [31:0] rom_waddr;
  logic [31:0] rom_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  rom_loader #(
    .ADDR_W(4),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rom_we   (rom_we),
    .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_we: got addr %h data %h, expected no write", rom_waddr, rom_wdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("we_addr", rom_waddr, e[63:32]);
        checkOutput("we_data", rom_wdata, e[31:0]);
      end
    end
  end

  task automatic applyStimulus_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic applyStimulus_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic applyStimulus_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus_byte(w[8*i +: 8]);
  endtask

  task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic waitEnd(input string name);
    int n = 0;
    while (!(done || err) && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput({name, "_ended"}, 32'(done || err), 32'd1);
  endtask

  task automatic checkFinal(input string name, input logic d, input logic e, input logic h);
    @(negedge clk);
    checkOutput({name, "_done"}, 32'(done), 32'(d));
    checkOutput({name, "_err"}, 32'(err), 32'(e));
    checkOutput({name, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_we"}, 32'(rom_we), 32'd0);
    checkOutput({name, "_waddr"}, rom_waddr, 32'd0);
    checkOutput({name, "_wdata"}, rom_wdata, 32'd0);
    checkOutput({name, "_flags"}, {28'd0, busy, done, err, cpu_hold}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 checkResetOutputs("reset");
    rst = 1'b0;

    // Two-word load
    applyStimulus_start();
    @(negedge clk);
    checkOutput("t1_busy_after_start", 32'(busy), 32'd1);
    checkOutput("t1_hold_after_start", 32'(cpu_hold), 32'd1);
    expectWrite(32'h0, 32'h12345678);
    expectWrite(32'h4, 32'hDEADBEEF);
    applyStimulus_word(32'd2);
    applyStimulus_word(32'h12345678);
    applyStimulus_word(32'hDEADBEEF);
`ifdef ROM_LOADER_CHECKSUM_EN
    applyStimulus_byte(8'h4C);
`endif
    waitEnd("t1");
    checkFinal("t1", 1'b1, 1'b0, 1'b0);

    // Zero-length load
    applyStimulus_start();
    applyStimulus_word(32'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
    applyStimulus_byte(8'h00);
`endif
    waitEnd("t2");
    checkFinal("t2", 1'b1, 1'b0, 1'b0);

    // Count one beyond ROM depth (16 words)
    applyStimulus_start();
    applyStimulus_word(32'd17);
    waitEnd("t3");
    @(negedge clk);
    checkOutput("t3_done", 32'(done), 32'd0);
    checkOutput("t3_err", 32'(err), 32'd1);
    checkOutput("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("t3_pending_writes", 32'(exp_q.size()), 32'd0);

    // Count exactly ROM depth: fills every word, new start clears err
    applyStimulus_start();
    @(negedge clk);
    checkOutput("t4_err_cleared", 32'(err), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b0;
      b0 = 8'(4 * i);
      expectWrite(32'(4 * i), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
    end
    applyStimulus_word(32'd16);
    for (int k = 0; k < 64; k++) applyStimulus_byte(8'(k));
`ifdef ROM_LOADER_CHECKSUM_EN
    applyStimulus_byte(8'hE0);
`endif
    waitEnd("t4");
    checkFinal("t4", 1'b1, 1'b0, 1'b0);

    // Timeout after two data bytes
    applyStimulus_start();
    applyStimulus_word(32'd1);
    applyStimulus_byte(8'hAA);
    applyStimulus_byte(8'hBB);
    repeat (85) @(negedge clk);
    checkOutput("t5_no_err_early", 32'(err), 32'd0);
    checkOutput("t5_busy_early", 32'(busy), 32'd1);
    repeat (25) @(negedge clk);
    checkOutput("t5_err", 32'(err), 32'd1);
    checkOutput("t5_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("t5_pending_writes", 32'(exp_q.size()), 32'd0);

    // Second start ignored mid-load, then reset after first word
    applyStimulus_start();
    expectWrite(32'h0, 32'h12345678);
    applyStimulus_word(32'd2);
    applyStimulus_start();
    applyStimulus_word(32'h12345678);
    checkOutput("t6_first_written", 32'(exp_q.size()), 32'd0);
    checkOutput("t6_busy_before_rst", 32'(busy), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1 checkResetOutputs("t6_reset");
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus_word(32'hDEADBEEF);
    repeat (5) @(negedge clk);
    checkResetOutputs("t6_after");

`ifdef ROM_LOADER_CHECKSUM_EN
    // Checksum good then bad
    applyStimulus_start();
    expectWrite(32'h0, 32'h04030201);
    applyStimulus_word(32'd1);
    applyStimulus_word(32'h04030201);
    applyStimulus_byte(8'h0A);
    waitEnd("t7a");
    checkFinal("t7a", 1'b1, 1'b0, 1'b0);
    applyStimulus_start();
    expectWrite(32'h0, 32'h04030201);
    applyStimulus_word(32'd1);
    applyStimulus_word(32'h04030201);
    applyStimulus_byte(8'h0B);
    waitEnd("t7b");
    checkFinal("t7b", 1'b0, 1'b1, 1'b1);
`endif

    repeat (3) @(negedge clk);
    checkOutput("final_pending_writes", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
